// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control path: opcodes, FSM states,
// datapath select codes and the decoded control word.
package cpu_ctrl_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_SUBI  = 3'b010;
  localparam logic [2:0] OP_ST    = 3'b011;
  localparam logic [2:0] OP_LD    = 3'b100;
  localparam logic [2:0] OP_JMP   = 3'b101;
  localparam logic [2:0] OP_BEQ   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // Opcodes the sequencer forces onto the ALU control decoder.
  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b110;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_I     = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  // Moore part of the control word; fetch/branch flag states needing input qualification.
  typedef struct packed {
    logic       fetch;
    logic       branch;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_re;
    logic       mem_we;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_opcode;
    logic       halted;
  } ctrl_t;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/cpu_seq_outdec.sv
// Combinational state-to-control-word decoder for the CPU sequencer.
// Only the opcode pass-through in EXEC_I looks at anything besides the state.
module cpu_seq_outdec
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [2:0] opcode,
  output ctrl_t      ctrl
);

  // Control word per state; unlisted fields stay idle with the ALU adding.
  always_comb begin
    ctrl            = '0;
    ctrl.pc_src     = PCSRC_ALU;
    ctrl.alu_src_b  = SRCB_REG;
    ctrl.alu_opcode = ALU_ADD;
    case (state)
      S_FETCH: begin
        ctrl.fetch     = 1'b1;
        ctrl.mem_re    = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_ONE;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_opcode = ALU_RTYPE;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_opcode = opcode;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.iord   = 1'b1;
        ctrl.mem_re = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.iord   = 1'b1;
        ctrl.mem_we = 1'b1;
      end
      S_WB_R: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = 1'b1;
      end
      S_WB_I: begin
        ctrl.reg_we  = 1'b1;
        ctrl.reg_dst = 1'b0;
      end
      S_WB_MEM: begin
        ctrl.reg_we     = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        ctrl.branch     = 1'b1;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_opcode = ALU_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_we  = 1'b1;
        ctrl.pc_src = PCSRC_JUMP;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: begin
        ctrl.alu_opcode = ALU_ADD;
      end
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle main control FSM: fetch/decode/execute/memory/writeback sequencing
// with a ready handshake, memory-timeout watchdog and halt/run control.
module cpu_seq_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       run,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_cond_we,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_re,
  output logic       mem_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_opcode,
  output logic       halted,
  output logic       err,
  output logic [3:0] state
);

  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam bit               TO_EN   = (MEM_TIMEOUT != 0);

  state_t           state_r;
  state_t           next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             err_r;
  logic             mem_state_s;
  logic             timeout_s;
  ctrl_t            dec_s;

  cpu_seq_outdec u_outdec (
    .state  (state_r),
    .opcode (opcode),
    .ctrl   (dec_s)
  );

  // Timeout fires only while an access is still pending; a late ready wins.
  always_comb begin
    mem_state_s = is_mem_state(state_r);
    timeout_s   = TO_EN && mem_state_s && !mem_ready && (cnt_r == TO_CNT);
  end

  // Next-state selection.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) begin
          next_s = S_DECODE;
        end else if (timeout_s) begin
          next_s = S_HALT;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:         next_s = S_EXEC_R;
          OP_ADDI, OP_SUBI: next_s = S_EXEC_I;
          OP_ST, OP_LD:     next_s = S_MEM_ADDR;
          OP_BEQ:           next_s = S_BRANCH;
          OP_JMP:           next_s = S_JUMP;
          OP_HALT:          next_s = S_HALT;
          default:          next_s = S_FETCH;
        endcase
      end
      S_EXEC_R: next_s = S_WB_R;
      S_EXEC_I: next_s = S_WB_I;
      S_MEM_ADDR: begin
        if (opcode == OP_LD) begin
          next_s = S_MEM_RD;
        end else begin
          next_s = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        if (mem_ready) begin
          next_s = S_WB_MEM;
        end else if (timeout_s) begin
          next_s = S_HALT;
        end else begin
          next_s = S_MEM_RD;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          next_s = S_FETCH;
        end else if (timeout_s) begin
          next_s = S_HALT;
        end else begin
          next_s = S_MEM_WR;
        end
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: next_s = S_FETCH;
      S_HALT: begin
        if (run && !err_r) begin
          next_s = S_FETCH;
        end else begin
          next_s = S_HALT;
        end
      end
      default: next_s = S_FETCH;
    endcase
  end

  // State register, sticky error flag and saturating wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH;
      cnt_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= next_s;
      if (timeout_s) begin
        err_r <= 1'b1;
      end
      // Any state change restarts the count, so each memory state enters at zero.
      if (next_s != state_r) begin
        cnt_r <= '0;
      end else if (mem_state_s && !mem_ready && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Output qualification; reset forces the idle word without waiting for a clock.
  always_comb begin
    if (rst) begin
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_cond_we = 1'b0;
      pc_src     = PCSRC_ALU;
      iord       = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      alu_opcode = ALU_ADD;
      halted     = 1'b0;
    end else begin
      ir_we      = dec_s.fetch & mem_ready;
      pc_we      = dec_s.pc_we | (dec_s.fetch & mem_ready);
      pc_cond_we = dec_s.branch & zero;
      pc_src     = dec_s.pc_src;
      iord       = dec_s.iord;
      mem_re     = dec_s.mem_re & !timeout_s;
      mem_we     = dec_s.mem_we & !timeout_s;
      reg_we     = dec_s.reg_we;
      reg_dst    = dec_s.reg_dst;
      mem_to_reg = dec_s.mem_to_reg;
      alu_src_a  = dec_s.alu_src_a;
      alu_src_b  = dec_s.alu_src_b;
      alu_opcode = dec_s.alu_opcode;
      halted     = dec_s.halted;
    end
  end

  assign err   = err_r;
  assign state = state_r;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: directed vector table, hand-written
// timeout/reset sequences and a randomized run against a path-queue model.
module tb_cpu_seq_ctrl;

  typedef struct packed {
    logic [3:0] state;
    logic       ir_we;
    logic       pc_we;
    logic       pc_cond_we;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_re;
    logic       mem_we;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_opcode;
    logic       halted;
    logic       err;
  } outs_t;

  typedef struct {
    logic [2:0] op;
    logic       z;
    logic       mr;
    logic       rn;
    outs_t      exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       run = 1'b0;
  logic       ir_we, pc_we, pc_cond_we, iord, mem_re, mem_we, reg_we, reg_dst;
  logic       mem_to_reg, alu_src_a, halted, err;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_opcode;
  logic [3:0] state;

  int n_chk = 0;
  int n_fail = 0;

  vec_t  vecs[$];
  int    m_state, m_wait;
  bit    m_err;
  int    m_path[$];

  cpu_seq_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready), .run(run),
    .ir_we(ir_we), .pc_we(pc_we), .pc_cond_we(pc_cond_we), .pc_src(pc_src), .iord(iord),
    .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_opcode(alu_opcode), .halted(halted), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  function automatic outs_t mk(input int st, input bit irw, input bit pcw, input bit pcc,
                               input int psrc, input bit io, input bit mre, input bit mwe,
                               input bit rwe, input bit rdst, input bit m2r, input bit asa,
                               input int asb, input int aop, input bit h, input bit e);
    outs_t o;
    o.state = 4'(st); o.ir_we = irw; o.pc_we = pcw; o.pc_cond_we = pcc;
    o.pc_src = 2'(psrc); o.iord = io; o.mem_re = mre; o.mem_we = mwe;
    o.reg_we = rwe; o.reg_dst = rdst; o.mem_to_reg = m2r; o.alu_src_a = asa;
    o.alu_src_b = 2'(asb); o.alu_opcode = 3'(aop); o.halted = h; o.err = e;
    return o;
  endfunction

  function automatic outs_t cur_out();
    outs_t o;
    o.state = state; o.ir_we = ir_we; o.pc_we = pc_we; o.pc_cond_we = pc_cond_we;
    o.pc_src = pc_src; o.iord = iord; o.mem_re = mem_re; o.mem_we = mem_we;
    o.reg_we = reg_we; o.reg_dst = reg_dst; o.mem_to_reg = mem_to_reg;
    o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b; o.alu_opcode = alu_opcode;
    o.halted = halted; o.err = err;
    return o;
  endfunction

  task automatic chk(input string nm, input outs_t act, input outs_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", nm, act, act.state, exp, exp.state);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at posedge+1: drive, compare mid-cycle, advance to the next posedge+1.
  task automatic step(input logic [2:0] op, input logic z, input logic mr, input logic rn,
                      input outs_t exp, input string nm);
    opcode = op; zero = z; mem_ready = mr; run = rn;
    #2;
    chk(nm, cur_out(), exp);
    @(posedge clk); #1;
  endtask

  task automatic add_vec(input logic [2:0] op, input logic z, input logic mr, input logic rn,
                         input outs_t exp);
    vec_t v;
    v.op = op; v.z = z; v.mr = mr; v.rn = rn; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Spec output table evaluated for the model's current phase.
  function automatic outs_t model_out(input int st, input logic [2:0] op, input logic z,
                                      input logic mr, input int wt, input bit e);
    outs_t o;
    bit    tmo;
    o = '0;
    o.state = 4'(st);
    o.alu_opcode = 3'b001;
    o.err = e;
    tmo = (st == 0 || st == 5 || st == 6) && !mr && (wt == 15);
    case (st)
      0:  begin o.mem_re = !tmo; o.alu_src_b = 2'b01; o.ir_we = mr; o.pc_we = mr; end
      1:  o.alu_src_b = 2'b10;
      2:  begin o.alu_src_a = 1'b1; o.alu_opcode = 3'b000; end
      3:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_opcode = op; end
      4:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      5:  begin o.iord = 1'b1; o.mem_re = !tmo; end
      6:  begin o.iord = 1'b1; o.mem_we = !tmo; end
      7:  begin o.reg_we = 1'b1; o.reg_dst = 1'b1; end
      8:  o.reg_we = 1'b1;
      9:  begin o.reg_we = 1'b1; o.mem_to_reg = 1'b1; end
      10: begin o.alu_src_a = 1'b1; o.alu_opcode = 3'b110; o.pc_src = 2'b01; o.pc_cond_we = z; end
      11: begin o.pc_we = 1'b1; o.pc_src = 2'b10; end
      12: o.halted = 1'b1;
      default: o.state = 4'(st);
    endcase
    return o;
  endfunction

  // Each instruction is a fixed list of phases after DECODE; memory phases stall.
  task automatic model_step(input logic [2:0] op, input logic mr, input logic rn);
    int  nxt;
    bit  memst;
    nxt = m_state;
    memst = (m_state == 0 || m_state == 5 || m_state == 6);
    if (memst) begin
      if (mr) begin
        if (m_state == 0) nxt = 1;
        else nxt = (m_path.size() > 0) ? m_path.pop_front() : 0;
      end else if (m_wait == 15) begin
        nxt = 12;
        m_err = 1'b1;
      end
    end else if (m_state == 1) begin
      m_path.delete();
      case (op)
        3'd0:       begin m_path.push_back(2); m_path.push_back(7); end
        3'd1, 3'd2: begin m_path.push_back(3); m_path.push_back(8); end
        3'd3:       begin m_path.push_back(4); m_path.push_back(6); end
        3'd4:       begin m_path.push_back(4); m_path.push_back(5); m_path.push_back(9); end
        3'd5:       m_path.push_back(11);
        3'd6:       m_path.push_back(10);
        default:    m_path.push_back(12);
      endcase
      nxt = m_path.pop_front();
    end else if (m_state == 12) begin
      if (rn && !m_err) nxt = 0;
    end else begin
      nxt = (m_path.size() > 0) ? m_path.pop_front() : 0;
    end
    if (nxt != m_state) m_wait = 0;
    else if (memst && !mr && m_wait < 15) m_wait++;
    m_state = nxt;
  endtask

  task automatic do_reset(input string nm, input outs_t e_rst);
    rst = 1'b1;
    mem_ready = 1'b0; run = 1'b0;
    @(posedge clk); #1;
    chk(nm, cur_out(), e_rst);
    rst = 1'b0;
  endtask

  initial begin
    outs_t e_f1, e_f0, e_dec, e_exr, e_exi, e_ma, e_mrd, e_mwr, e_wbr, e_wbi, e_wbm;
    outs_t e_br1, e_br0, e_jmp, e_hlt, e_hlte, e_rst;
    int    cnt_we;
    logic [2:0] r_op;
    logic  r_z, r_mr, r_rn;
    outs_t r_exp;

    e_f1  = mk(0, 1,1,0,0, 0,1,0, 0,0,0, 0,1,1, 0,0);
    e_f0  = mk(0, 0,0,0,0, 0,1,0, 0,0,0, 0,1,1, 0,0);
    e_dec = mk(1, 0,0,0,0, 0,0,0, 0,0,0, 0,2,1, 0,0);
    e_exr = mk(2, 0,0,0,0, 0,0,0, 0,0,0, 1,0,0, 0,0);
    e_exi = mk(3, 0,0,0,0, 0,0,0, 0,0,0, 1,2,2, 0,0);
    e_ma  = mk(4, 0,0,0,0, 0,0,0, 0,0,0, 1,2,1, 0,0);
    e_mrd = mk(5, 0,0,0,0, 1,1,0, 0,0,0, 0,0,1, 0,0);
    e_mwr = mk(6, 0,0,0,0, 1,0,1, 0,0,0, 0,0,1, 0,0);
    e_wbr = mk(7, 0,0,0,0, 0,0,0, 1,1,0, 0,0,1, 0,0);
    e_wbi = mk(8, 0,0,0,0, 0,0,0, 1,0,0, 0,0,1, 0,0);
    e_wbm = mk(9, 0,0,0,0, 0,0,0, 1,0,1, 0,0,1, 0,0);
    e_br1 = mk(10, 0,0,1,1, 0,0,0, 0,0,0, 1,0,6, 0,0);
    e_br0 = mk(10, 0,0,0,1, 0,0,0, 0,0,0, 1,0,6, 0,0);
    e_jmp = mk(11, 0,1,0,2, 0,0,0, 0,0,0, 0,0,1, 0,0);
    e_hlt = mk(12, 0,0,0,0, 0,0,0, 0,0,0, 0,0,1, 1,0);
    e_hlte= mk(12, 0,0,0,0, 0,0,0, 0,0,0, 0,0,1, 1,1);
    e_rst = mk(0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,1, 0,0);

    // R-type add with zero-wait memory
    add_vec(3'd0,0,1,0,e_f1); add_vec(3'd0,0,1,0,e_dec); add_vec(3'd0,1,1,0,e_exr); add_vec(3'd0,0,0,0,e_wbr);
    // ld with fetch stall and three wait cycles in MEM_RD
    add_vec(3'd4,0,0,0,e_f0); add_vec(3'd4,0,1,0,e_f1); add_vec(3'd4,0,0,0,e_dec); add_vec(3'd4,0,0,0,e_ma);
    add_vec(3'd4,0,0,0,e_mrd); add_vec(3'd4,0,0,0,e_mrd); add_vec(3'd4,0,0,0,e_mrd); add_vec(3'd4,0,1,0,e_mrd);
    add_vec(3'd4,0,0,0,e_wbm);
    // beq taken then not taken
    add_vec(3'd6,0,1,0,e_f1); add_vec(3'd6,0,0,0,e_dec); add_vec(3'd6,1,0,0,e_br1);
    add_vec(3'd6,1,1,0,e_f1); add_vec(3'd6,1,0,0,e_dec); add_vec(3'd6,0,0,0,e_br0);
    // subi, st
    add_vec(3'd2,0,1,0,e_f1); add_vec(3'd2,0,0,0,e_dec); add_vec(3'd2,0,0,0,e_exi); add_vec(3'd2,0,0,0,e_wbi);
    add_vec(3'd3,0,1,0,e_f1); add_vec(3'd3,0,0,0,e_dec); add_vec(3'd3,0,0,0,e_ma); add_vec(3'd3,0,0,0,e_mwr);
    add_vec(3'd3,0,1,0,e_mwr);
    // halt, ignored mem_ready, run restarts, then a jump
    add_vec(3'd7,0,1,0,e_f1); add_vec(3'd7,0,0,0,e_dec); add_vec(3'd7,0,0,0,e_hlt); add_vec(3'd7,0,1,0,e_hlt);
    add_vec(3'd5,0,0,1,e_hlt); add_vec(3'd5,0,0,0,e_f0); add_vec(3'd5,0,1,0,e_f1); add_vec(3'd5,0,0,0,e_dec);
    add_vec(3'd5,0,0,0,e_jmp);

    @(posedge clk); #1;
    do_reset("reset_state", e_rst);
    @(posedge clk); #1;
    foreach (vecs[i]) step(vecs[i].op, vecs[i].z, vecs[i].mr, vecs[i].rn, vecs[i].exp,
                           $sformatf("vec[%0d]", i));

    // st with memory never ready: watchdog trips and halt is sticky
    step(3'd3,0,1,0,e_f1,"to_fetch"); step(3'd3,0,0,0,e_dec,"to_decode"); step(3'd3,0,0,0,e_ma,"to_addr");
    cnt_we = 0;
    for (int i = 0; i < 40; i++) begin
      mem_ready = 1'b0;
      #2;
      if (state == 4'd12) break;
      if (mem_we && state == 4'd6) cnt_we++;
      @(posedge clk); #1;
    end
    chk_int("timeout_mem_we_cycles", cnt_we, 15);
    step(3'd3,0,0,0,e_hlte,"timeout_halt_err");
    step(3'd3,0,0,1,e_hlte,"timeout_run_ignored");
    step(3'd3,0,1,1,e_hlte,"timeout_still_halted");

    // asynchronous reset in the middle of a store
    do_reset("reset_after_err", e_rst);
    @(posedge clk); #1;
    step(3'd3,0,1,0,e_f1,"mid_fetch"); step(3'd3,0,0,0,e_dec,"mid_decode");
    step(3'd3,0,0,0,e_ma,"mid_addr"); step(3'd3,0,0,0,e_mwr,"mid_memwr");
    mem_ready = 1'b0;
    #1 chk_int("mid_mem_we_before_rst", int'(mem_we), 1);
    #1 rst = 1'b1;
    #1 chk_int("mid_mem_we_async", int'(mem_we), 0);
    chk_int("mid_state_async", int'(state), 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    step(3'd1,0,0,0,e_f0,"resume_fetch_wait"); step(3'd1,0,1,0,e_f1,"resume_fetch");
    step(3'd1,0,0,0,e_dec,"resume_decode");

    // randomized run against the phase-list model
    do_reset("reset_random", e_rst);
    m_state = 0; m_wait = 0; m_err = 1'b0; m_path.delete();
    r_op = 3'd0;
    for (int i = 0; i < 3000; i++) begin
      if (m_state == 0) r_op = 3'($urandom_range(0, 7));
      r_z  = 1'($urandom_range(0, 1));
      r_mr = ($urandom_range(0, 9) < 7);
      r_rn = 1'($urandom_range(0, 1));
      r_exp = model_out(m_state, r_op, r_z, r_mr, m_wait, m_err);
      step(r_op, r_z, r_mr, r_rn, r_exp, $sformatf("rand[%0d]", i));
      model_step(r_op, r_mr, r_rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
